// File: rtl/cdc_handshake_fifo.sv
// Asynchronous dual-clock FIFO: gray-coded pointers cross domains through synchroniser chains,
// and the read side falls through into a registered valid/ready output stage.
module cdc_handshake_fifo #(
   parameter int unsigned           DATA_WIDTH      = 32,
   parameter int unsigned           ADDR_WIDTH      = 2,
   parameter int unsigned           SYNC_STAGES     = 2,
   parameter logic [DATA_WIDTH-1:0] OUT_RESET_VALUE = '0
) (
   input  logic                  i_IClk,
   input  logic                  i_aIReset_N,
   input  logic                  i_iPush,
   input  logic [DATA_WIDTH-1:0] i_iData,
   output logic                  o_iReady,
   output logic                  o_iOverflow,
   output logic [ADDR_WIDTH:0]   o_iLevel,
   input  logic                  i_OClk,
   input  logic                  i_aOReset_N,
   output logic                  o_oDataValid,
   output logic [DATA_WIDTH-1:0] o_oData,
   input  logic                  i_oReady,
   output logic [ADDR_WIDTH:0]   o_oLevel
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned PW    = ADDR_WIDTH + 1;

   typedef logic [PW-1:0] ptr_t;

   // Gray code of a full pointer with its top two bits flipped marks "DEPTH ahead".
   localparam ptr_t FULL_MASK = ptr_t'(3) << (ADDR_WIDTH - 1);

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[PW-1] = g[PW-1];
      for (int unsigned i = PW - 1; i > 0; i--) begin
         b[i-1] = b[i] ^ g[i-1];
      end
      return b;
   endfunction

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   ptr_t wBin, wGray, wBinNext, wGrayNext;
   ptr_t rBin, rGray, rBinNext;
   ptr_t rSyncI [SYNC_STAGES];
   ptr_t wSyncO [SYNC_STAGES];
   logic wEn, rEmpty, rLoad;

   // ---------------- write side (IClk) ----------------
   assign wEn       = i_iPush & o_iReady;
   assign wBinNext  = wBin + ptr_t'(wEn);
   assign wGrayNext = bin2gray(wBinNext);
   assign o_iLevel  = wBin - gray2bin(rSyncI[SYNC_STAGES-1]);

   always_ff @(posedge i_IClk or negedge i_aIReset_N) begin
      if (!i_aIReset_N) begin
         wBin        <= '0;
         wGray       <= '0;
         o_iReady    <= 1'b0;
         o_iOverflow <= 1'b0;
      end else begin
         wBin        <= wBinNext;
         wGray       <= wGrayNext;
         o_iReady    <= (wGrayNext != (rSyncI[SYNC_STAGES-1] ^ FULL_MASK));
         o_iOverflow <= i_iPush & ~o_iReady;
      end
   end

   always_ff @(posedge i_IClk) begin
      if (wEn) begin
         mem[wBin[ADDR_WIDTH-1:0]] <= i_iData;
      end
   end

   always_ff @(posedge i_IClk or negedge i_aIReset_N) begin
      if (!i_aIReset_N) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) rSyncI[i] <= '0;
      end else begin
         rSyncI[0] <= rGray;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) rSyncI[i] <= rSyncI[i-1];
      end
   end

   // ---------------- read side (OClk) ----------------
   assign rEmpty   = (rGray == wSyncO[SYNC_STAGES-1]);
   assign rLoad    = ~rEmpty & (~o_oDataValid | i_oReady);
   assign rBinNext = rBin + ptr_t'(rLoad);
   assign o_oLevel = gray2bin(wSyncO[SYNC_STAGES-1]) - rBin;

   always_ff @(posedge i_OClk or negedge i_aOReset_N) begin
      if (!i_aOReset_N) begin
         rBin         <= '0;
         rGray        <= '0;
         o_oDataValid <= 1'b0;
         o_oData      <= OUT_RESET_VALUE;
      end else begin
         rBin  <= rBinNext;
         rGray <= bin2gray(rBinNext);
         if (rLoad) begin
            o_oData      <= mem[rBin[ADDR_WIDTH-1:0]];
            o_oDataValid <= 1'b1;
         end else if (i_oReady) begin
            o_oDataValid <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_OClk or negedge i_aOReset_N) begin
      if (!i_aOReset_N) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) wSyncO[i] <= '0;
      end else begin
         wSyncO[0] <= wGray;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) wSyncO[i] <= wSyncO[i-1];
      end
   end

endmodule
